// File: rtl/sixty_four_bit_serial_sub_pkg.sv
// Shared sizing constants and FSM encoding for the 64-bit serial subtractor.
// Operands are processed SLICE bits per clock, least-significant slice first.
package sub_pkg;

    localparam int unsigned WIDTH      = 64;
    localparam int unsigned SLICE      = 16;
    localparam int unsigned NUM_SLICES = WIDTH / SLICE;
    localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic is_last_slice(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(NUM_SLICES - 1);
    endfunction

endpackage

// File: rtl/sixty_four_bit_serial_sub_if.sv
// Operand/result bundle between a sequential ALU controller (master) and the
// serial subtractor (slave).
interface sixty_four_bit_serial_sub_if;
    import sub_pkg::*;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             zero;
    logic             overflow;

    modport master (
        output start,
        output a,
        output b,
        output b_in,
        input  busy,
        input  done,
        input  diff,
        input  b_out,
        input  zero,
        input  overflow
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  b_in,
        output busy,
        output done,
        output diff,
        output b_out,
        output zero,
        output overflow
    );

endinterface

// File: rtl/sixteen_bit_sub_slice.sv
// Combinational subtract slice: d = a - b - borrow_in, computed as a + ~b + ~borrow_in.
module sixteen_bit_sub_slice #(
    parameter int unsigned Width = 16
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             borrow_in,
    output logic [Width-1:0] d,
    output logic             borrow_out
);

    logic [Width:0] sum;

    always_comb begin
        sum        = {1'b0, a} + {1'b0, ~b} + {{Width{1'b0}}, ~borrow_in};
        d          = sum[Width-1:0];
        // No carry out of the inverted-subtrahend sum means a borrow was taken.
        borrow_out = ~sum[Width];
    end

endmodule

// File: rtl/sixty_four_bit_serial_sub.sv
// 64-bit subtractor behind a start/done handshake, one 16-bit slice per clock.
// The borrow crosses slice boundaries only through borrow_q.
module sixty_four_bit_serial_sub
    import sub_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    sixty_four_bit_serial_sub_if.slave  bus
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] d_slice;
    logic             slice_borrow;
    logic             accept;

    assign a_slice = a_q[idx_q*SLICE +: SLICE];
    assign b_slice = b_q[idx_q*SLICE +: SLICE];

    sixteen_bit_sub_slice #(
        .Width(SLICE)
    ) u_slice (
        .a         (a_slice),
        .b         (b_slice),
        .borrow_in (borrow_q),
        .d         (d_slice),
        .borrow_out(slice_borrow)
    );

    // A request arriving in the done cycle is taken, giving one op per five cycles.
    assign accept = (state_q != StRun) && bus.start;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d  = StRun;
                    idx_d    = '0;
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.b_in;
                    diff_d   = '0;
                    b_out_d  = 1'b0;
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                diff_d[idx_q*SLICE +: SLICE] = d_slice;
                borrow_d                     = slice_borrow;
                if (is_last_slice(idx_q)) begin
                    state_d = StDone;
                    b_out_d = slice_borrow;
                    zero_d  = (diff_d == '0);
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            b_out_q  <= b_out_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == StRun);
    assign bus.done     = (state_q == StDone);
    assign bus.diff     = diff_q;
    assign bus.b_out    = b_out_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_sixty_four_bit_serial_sub.sv
// Directed bench for the serial subtractor: arithmetic corners, handshake timing
// and mid-operation reset, with hand-computed expected results.
module tb_sixty_four_bit_serial_sub;
    import sub_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sixty_four_bit_serial_sub_if bus ();

    sixty_four_bit_serial_sub dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge; returns 1 ns after the accept edge.
    task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic bin);
        bus.a     = a;
        bus.b     = b;
        bus.b_in  = bin;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic bin, input logic [63:0] exp_diff, input logic exp_bo,
                          input logic exp_z, input logic exp_ov);
        int lat;
        launch(a, b, bin);
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        wait_done(lat);
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_diff"}, bus.diff, exp_diff);
        check({tag, "_b_out"}, 64'(bus.b_out), 64'(exp_bo));
        check({tag, "_zero"}, 64'(bus.zero), 64'(exp_z));
        check({tag, "_overflow"}, 64'(bus.overflow), 64'(exp_ov));
        step();
        check({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
        check({tag, "_diff_held"}, bus.diff, exp_diff);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int extra;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.b_in  = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_diff", bus.diff, 64'd0);
        check("rst_b_out", 64'(bus.b_out), 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);

        run_op("ten_minus_three", 64'd10, 64'd3, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);
        run_op("zero_minus_one", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("equal_borrow_in", 64'h1234, 64'h1234, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               1'b0);
        run_op("cross_slice", 64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0,
               1'b0, 1'b0);
        run_op("equal_zero", 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'd0, 1'b0,
               1'b1, 1'b0);
        run_op("signed_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0,
               1'b0, 1'b1);
        run_op("high_slice_borrow", 64'h0001_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1,
               64'h0000_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // start held through RUN: single operation, single done
        bus.a     = 64'd5;
        bus.b     = 64'd2;
        bus.b_in  = 1'b0;
        bus.start = 1'b1;
        step();
        wait_done(lat);
        bus.start = 1'b0;
        check("hold_latency", 64'(lat), 64'd4);
        check("hold_diff", bus.diff, 64'd3);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        check("hold_no_restart", 64'(extra), 64'd0);

        // back-to-back: start in the done cycle is accepted
        launch(64'd100, 64'd1, 1'b0);
        wait_done(lat);
        check("b2b_first_diff", bus.diff, 64'd99);
        bus.a     = 64'd7;
        bus.b     = 64'd9;
        bus.b_in  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("b2b_done_drop", 64'(bus.done), 64'd0);
        check("b2b_busy", 64'(bus.busy), 64'd1);
        check("b2b_diff_cleared", bus.diff, 64'd0);
        wait_done(lat);
        check("b2b_latency", 64'(lat), 64'd4);
        check("b2b_second_diff", bus.diff, 64'hFFFF_FFFF_FFFF_FFFE);
        check("b2b_second_b_out", 64'(bus.b_out), 64'd1);
        check("b2b_second_ovf", 64'(bus.overflow), 64'd0);
        step();

        // reset after slice 2 is written aborts the operation
        launch(64'd1, 64'd2, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_diff", bus.diff, 64'd0);
        check("abort_b_out", 64'(bus.b_out), 64'd0);
        check("abort_zero", 64'(bus.zero), 64'd0);
        check("abort_overflow", 64'(bus.overflow), 64'd0);
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.done === 1'b1) extra++;
        end
        check("abort_no_done", 64'(extra), 64'd0);

        // rst and start together: rst wins
        bus.a     = 64'd9;
        bus.b     = 64'd4;
        bus.start = 1'b1;
        rst       = 1'b1;
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", 64'(bus.busy), 64'd0);
        step();
        check("rst_start_busy_later", 64'(bus.busy), 64'd0);
        check("rst_start_diff", bus.diff, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
